// File: rtl/video_timing_pkg.sv
// Shared definitions for the video pattern generator: mode encodings, the colour-bar palette
// and the standard 800x600@60 timing set used as parameter defaults.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // 800x600@60 (40 MHz class) timing
  localparam int unsigned STD_H_ACTIVE = 800;
  localparam int unsigned STD_H_FRONT  = 40;
  localparam int unsigned STD_H_SYNC   = 128;
  localparam int unsigned STD_H_BACK   = 88;
  localparam int unsigned STD_V_ACTIVE = 600;
  localparam int unsigned STD_V_FRONT  = 1;
  localparam int unsigned STD_V_SYNC   = 4;
  localparam int unsigned STD_V_BACK   = 23;
  localparam int unsigned STD_CNT_W    = 12;

  // Bar index 0..7, left to right
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    c = BAR_BLACK;
    case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster counters plus combinational (pre-register) sync levels, active flag and position
// strobes. The parent registers everything so all video outputs share one cycle of latency.
module video_timing_core #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FRONT  = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 23,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk_27,
  input  logic             rst,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             active,
  output logic             hs_lvl,
  output logic             vs_lvl,
  output logic             line_end,
  output logic             frame_end,
  output logic             frame_first
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  assign line_end    = (h_q == H_LAST);
  assign frame_end   = line_end && (v_q == V_LAST);
  assign frame_first = (h_q == '0) && (v_q == '0);
  assign active      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_lvl      = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
  assign vs_lvl      = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
  assign h           = h_q;
  assign v           = v_q;

  // Next raster position: h wraps each line, v advances on each h wrap
  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  // Counter state, synchronous reset to the top-left pixel
  always_ff @(posedge clk_27) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern generator (solid, colour bars, checkerboard, grey
// gradient). Mode and solid colour are shadowed and only change at frame boundaries.
// Optional macro PATTERN_SCROLL_EN: per-frame counter scrolls the gradient and checkerboard.
// CNT_W must be at least 8 (gradient uses h[7:0]).
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = STD_H_ACTIVE,
  parameter int unsigned H_FRONT    = STD_H_FRONT,
  parameter int unsigned H_SYNC     = STD_H_SYNC,
  parameter int unsigned H_BACK     = STD_H_BACK,
  parameter int unsigned V_ACTIVE   = STD_V_ACTIVE,
  parameter int unsigned V_FRONT    = STD_V_FRONT,
  parameter int unsigned V_SYNC     = STD_V_SYNC,
  parameter int unsigned V_BACK     = STD_V_BACK,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CNT_W      = STD_CNT_W,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic        clk_27,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  rgb_red,
  output logic [7:0]  rgb_green,
  output logic [7:0]  rgb_blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  // Narrow active widths still get a usable bar counter
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] h, v;
  logic             active, hs_lvl, vs_lvl, line_end, frame_end, frame_first;

  video_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clk_27      (clk_27),
    .rst         (rst),
    .h           (h),
    .v           (v),
    .active      (active),
    .hs_lvl      (hs_lvl),
    .vs_lvl      (vs_lvl),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .frame_first (frame_first)
  );

  mode_e       mode_q;
  logic [23:0] solid_q;

  // Shadow registers: load while in reset and on the last pixel of each frame only
  always_ff @(posedge clk_27) begin
    if (rst || frame_end) begin
      mode_q  <= mode_e'(mode);
      solid_q <= solid_rgb;
    end
  end

  logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_q, bar_d;

  // Bar index tracks the current h without a divider; saturates so remainder pixels are bar 7
  always_comb begin
    bar_cnt_d = bar_cnt_q + CNT_W'(1);
    bar_d     = bar_q;
    if (line_end) begin
      bar_cnt_d = '0;
      bar_d     = 3'd0;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_d = '0;
      bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
    end
  end

  // Bar counter state, aligned with h = 0 after reset
  always_ff @(posedge clk_27) begin
    if (rst) begin
      bar_cnt_q <= '0;
      bar_q     <= 3'd0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
    end
  end

  logic [7:0] scroll_off;

`ifdef PATTERN_SCROLL_EN
  logic [7:0] fcnt_q;

  // Frame counter advances on the frame boundary so the offset is constant across a frame
  always_ff @(posedge clk_27) begin
    if (rst) begin
      fcnt_q <= 8'd0;
    end else if (frame_end) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign scroll_off = fcnt_q;
`else
  assign scroll_off = 8'd0;
`endif

  logic [23:0] pix_d;
  logic        chk_x, chk_y;
  logic [7:0]  grad;

  // Pattern mux; blanking forces black regardless of mode
  always_comb begin
    pix_d = 24'h000000;
    chk_x = 1'((h + CNT_W'(scroll_off)) >> CHECK_LOG2);
    chk_y = 1'(v >> CHECK_LOG2);
    grad  = h[7:0] + scroll_off;
    if (active) begin
      unique case (mode_q)
        MODE_SOLID: pix_d = solid_q;
        MODE_BARS:  pix_d = bar_color(bar_q);
        MODE_CHECK: pix_d = (chk_x ^ chk_y) ? 24'hFFFFFF : 24'h000000;
        MODE_GRAD:  pix_d = {grad, grad, grad};
        default:    pix_d = 24'h000000;
      endcase
    end
  end

  // Output register: one cycle after the counter state, all outputs aligned
  always_ff @(posedge clk_27) begin
    if (rst) begin
      rgb_red     <= 8'd0;
      rgb_green   <= 8'd0;
      rgb_blue    <= 8'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb_red     <= pix_d[23:16];
      rgb_green   <= pix_d[15:8];
      rgb_blue    <= pix_d[7:0];
      hsync       <= hs_lvl;
      vsync       <= vs_lvl;
      de          <= active;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench: two generator instances (active-low sync, 16-pixel lines; active-high
// sync, 20-pixel lines with bar remainder) against a cycle-count based reference model.
module tb_video_pattern_gen;

  localparam int A_HA = 16;
  localparam int B_HA = 20;
  localparam int HF   = 2;
  localparam int HS   = 3;
  localparam int HB   = 3;
  localparam int VA   = 8;
  localparam int VF   = 1;
  localparam int VS   = 2;
  localparam int VB   = 1;

  logic        clk_27 = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h123456;

  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic       a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;

  always #5 clk_27 = ~clk_27;

  video_pattern_gen #(
    .H_ACTIVE (A_HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .HS_POL (1'b0), .VS_POL (1'b0), .CNT_W (12), .CHECK_LOG2 (2)
  ) dut_a (
    .clk_27 (clk_27), .rst (rst), .mode (mode), .solid_rgb (solid_rgb),
    .rgb_red (a_r), .rgb_green (a_g), .rgb_blue (a_b),
    .hsync (a_hs), .vsync (a_vs), .de (a_de), .frame_start (a_fs)
  );

  video_pattern_gen #(
    .H_ACTIVE (B_HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .HS_POL (1'b1), .VS_POL (1'b1), .CNT_W (12), .CHECK_LOG2 (1)
  ) dut_b (
    .clk_27 (clk_27), .rst (rst), .mode (mode), .solid_rgb (solid_rgb),
    .rgb_red (b_r), .rgb_green (b_g), .rgb_blue (b_b),
    .hsync (b_hs), .vsync (b_vs), .de (b_de), .frame_start (b_fs)
  );

  // Reference model configuration per instance
  int   ha   [2] = '{A_HA, B_HA};
  int   ck   [2] = '{2, 1};
  bit   hpol [2] = '{1'b0, 1'b1};
  bit   vpol [2] = '{1'b0, 1'b1};
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Model state: cycles since reset release and the settings latched for the current frame
  int          n  [2];
  logic [1:0]  em [2];
  logic [23:0] es [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic int frame_len(int k);
    return (ha[k] + HF + HS + HB) * (VA + VF + VS + VB);
  endfunction

  // Expected {rgb, hsync, vsync, de, frame_start} for the nn-th cycle after reset
  function automatic logic [27:0] expect_out(int k, int nn, logic [1:0] md, logic [23:0] sc);
    int ht, h, v, f, off, idx, g;
    bit act, hs_on, vs_on;
    logic [23:0] rgb;
    ht    = ha[k] + HF + HS + HB;
    h     = nn % ht;
    v     = (nn / ht) % (VA + VF + VS + VB);
    f     = nn / frame_len(k);
`ifdef PATTERN_SCROLL_EN
    off   = f % 256;
`else
    off   = 0;
`endif
    act   = (h < ha[k]) && (v < VA);
    hs_on = (h >= ha[k] + HF) && (h < ha[k] + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    rgb   = 24'h000000;
    if (act) begin
      case (md)
        2'd0: rgb = sc;
        2'd1: begin
          idx = h / (ha[k] / 8);
          if (idx > 7) idx = 7;
          rgb = bars[idx];
        end
        2'd2: rgb = ((((h + off) >> ck[k]) ^ (v >> ck[k])) & 1) != 0 ? 24'hFFFFFF : 24'h0;
        default: begin
          g   = (h + off) % 256;
          rgb = {8'(g), 8'(g), 8'(g)};
        end
      endcase
    end
    return {rgb, hs_on ? hpol[k] : ~hpol[k], vs_on ? vpol[k] : ~vpol[k], act,
            (h == 0) && (v == 0)};
  endfunction

  // One clock: predict from the pre-edge state, then compare #1 after the edge
  task automatic step();
    logic [27:0] exp_v [2];
    logic [27:0] obs_a, obs_b;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_v[k] = {24'h0, ~hpol[k], ~vpol[k], 2'b00};
        n[k]     = 0;
        em[k]    = mode;
        es[k]    = solid_rgb;
      end else begin
        exp_v[k] = expect_out(k, n[k], em[k], es[k]);
        if (n[k] % frame_len(k) == frame_len(k) - 1) begin
          em[k] = mode;
          es[k] = solid_rgb;
        end
        n[k]++;
      end
    end
    @(posedge clk_27);
    #1;
    cyc++;
    obs_a = {a_r, a_g, a_b, a_hs, a_vs, a_de, a_fs};
    obs_b = {b_r, b_g, b_b, b_hs, b_vs, b_de, b_fs};
    checks++;
    assert (obs_a === exp_v[0]) else begin
      errors++;
      $error("FAIL dut_a cyc %0d {rgb,hs,vs,de,fs}: observed %h expected %h",
             cyc, obs_a, exp_v[0]);
    end
    checks++;
    assert (obs_b === exp_v[1]) else begin
      errors++;
      $error("FAIL dut_b cyc %0d {rgb,hs,vs,de,fs}: observed %h expected %h",
             cyc, obs_b, exp_v[1]);
    end
  endtask

  task automatic run(int cycles);
    repeat (cycles) step();
  endtask

  initial begin
    // Reset with solid 123456
    mode      = 2'd0;
    solid_rgb = 24'h123456;
    rst       = 1'b1;
    run(3);
    rst = 1'b0;
    run(350);

    // Solid -> gradient mid-frame; takes effect next frame
    mode = 2'd3;
    run(700);

    // Colour bars, then checkerboard
    mode = 2'd1;
    run(700);
    mode = 2'd2;
    run(700);

    // Random mode/colour changes at random points in the frame
    repeat (24) begin
      mode      = 2'($urandom_range(0, 3));
      solid_rgb = $urandom;
      run(int'($urandom_range(1, 200)));
    end

    // Reset mid-line, then resume
    run(int'($urandom_range(3, 12)));
    rst       = 1'b1;
    mode      = 2'd0;
    solid_rgb = $urandom;
    run(2);
    rst = 1'b0;
    run(400);
    mode = 2'd2;
    run(int'($urandom_range(50, 150)));
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(700);

`ifdef PATTERN_SCROLL_EN
    // Gradient scroll through the 255 -> 0 wrap of the frame counter
    mode = 2'd3;
    rst  = 1'b1;
    run(1);
    rst = 1'b0;
    run(257 * frame_len(0) + 40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
